out_fsm: RTL and testbench
==========================

# out_fsm

Instruction-execution FSM for the OUT instruction (opcode 4'b1000) in the microcontroller control unit. It is the read-side counterpart of the MOVI immediate-write sequence. It selects one architectural register (G0–G3, P0, P1) onto the shared 16-bit bus, captures the bus value, and presents it to an external output port over a valid/ready handshake. It runs alongside the other per-opcode FSMs, all sharing `fullBitNum`, `IF_active`, the bus and the PC-increment line.

## Interface
- `OPCODE`, 4'b1000: opcode (`fullBitNum[15:12]`) that enables this FSM.
- `TIMEOUT`, 8'd255: maximum HOLD cycles spent waiting for `port_ready`; 0 disables the timeout.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `IF_active`  in  1  instruction fetch in progress; forces IDLE.
- `fullBitNum`  in  16  current instruction; `[11:6]` = source register code, `[5:0]` ignored.
- `bus_in`  in  16  shared data bus.
- `port_ready`  in  1  external consumer accepts `port_data`.
- `G0_out, G1_out, G2_out, G3_out, P0_out, P1_out`  out  1 each  register-to-bus output enables; at most one high.
- `PC_inc`  out  1  program-counter increment request.
- `port_data`  out  16  captured register value.
- `port_valid`  out  1  `port_data` is valid.
- `err`  out  1  last OUT had an illegal source code or timed out; sticky until next IDLE→INC.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Source codes are the same as MOVI: 0=G0, 1=P0, 2=G1, 3=G2, 4=G3, 5=P1. Codes 6–63 are illegal.
- States and transitions:
  - IDLE: go to INC when opcode==`OPCODE` and !`IF_active`.
  - INC: `PC_inc`=1. Go to SEL.
  - SEL: assert the source `*_out` enable so the bus settles. On an illegal code, drive no enable, set `err`, and go to DONE. Otherwise go to CAP.
  - CAP: hold the same enable; `port_data` <= `bus_in` at the edge leaving CAP. Go to HOLD.
  - HOLD: `port_valid`=1. A transfer completes at the edge where `port_valid`&&`port_ready`; then go to DONE. When the wait counter reaches `TIMEOUT` (nonzero) with no transfer, set `err` and go to DONE.
  - DONE: `done`=1. Go to PARK.
  - PARK: all control outputs 0. Stay until opcode changes or `IF_active`.
- From any state, `IF_active`=1 or opcode≠`OPCODE` forces IDLE at the next edge. This aborts a pending handshake: `port_valid` drops, `port_data` is retained.
- Outputs `*_out`, `PC_inc`, `port_valid` and `done` are Moore outputs decoded from the registered state.
- `port_data`, `err` and the wait counter are registered.
- Wait counter: 8-bit, cleared on entry to HOLD, +1 per HOLD cycle, saturating at `TIMEOUT`.
- `port_data` is unchanged outside the CAP→HOLD edge.
- `err` clears on the IDLE→INC edge.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE; `port_data`=16'h0000; `err`, `done`, `port_valid`, `PC_inc`, all `*_out`=0; counter=0.
- With opcode present at edge 0:
  - INC during cycle 1, SEL cycle 2, CAP cycle 3, HOLD from cycle 4.
  - With `port_ready` already high, the transfer occurs at the end of cycle 4, `done` is high in cycle 5, and PARK begins at cycle 6.
- Each cycle of `port_ready` low in HOLD adds one cycle of latency.
- `port_valid`, once high, never drops without a transfer, except on timeout, abort or reset.
- Illegal source code: `done` is high in cycle 3; `port_valid` is never asserted.
- `IF_active` and the opcode match both high in the same cycle: `IF_active` wins.
- Reset mid-HOLD: `port_valid` falls asynchronously and `port_data` clears.

## Structure
- Shared package `uc_pkg`: opcode constants (OP_MOVI=4'b0111, OP_OUT=4'b1000), the register-code constants 0–5, and the state encoding (3-bit: IDLE=0, INC=1, SEL=2, CAP=3, HOLD=4, DONE=5, PARK=6).
- One sub-module `reg_sel_decode`: 6-bit code plus enable in, six one-hot enables plus a `legal` flag out. It is reused by the MOVI-side logic.

## Test plan
- Source G2 holding 16'hBEEF (code 3), `port_ready` tied high: `G2_out` high in cycles 2–3 only; `port_data`=16'hBEEF, `port_valid` high in cycle 4; `done` in cycle 5.
- Source P1 (code 5) with `port_ready` held low 10 cycles then high: `port_valid` stays high for 11 cycles and `port_data` is stable; `done` follows the transfer by one cycle.
- `TIMEOUT`=4, `port_ready` never high: `port_valid` high for 4 cycles, then `err`=1 and `done`=1; the next OUT clears `err` at its INC.
- Source code 6'd9: no `*_out` asserted, `err`=1, `done` in cycle 3, `port_data` unchanged.
- `IF_active` pulsed during HOLD: `port_valid` drops next edge, FSM returns to IDLE, `done` is never asserted.
- `rst` pulled low mid-CAP: all outputs 0 immediately and `port_data`=0. After release with the OUT opcode still present, the sequence restarts at INC.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared control-unit definitions: opcodes, register source codes and the
// state encoding used by the per-opcode execution FSMs.
package uc_pkg;

  localparam logic [3:0] OP_MOVI = 4'b0111;
  localparam logic [3:0] OP_OUT  = 4'b1000;

  localparam logic [5:0] RC_G0 = 6'd0;
  localparam logic [5:0] RC_P0 = 6'd1;
  localparam logic [5:0] RC_G1 = 6'd2;
  localparam logic [5:0] RC_G2 = 6'd3;
  localparam logic [5:0] RC_G3 = 6'd4;
  localparam logic [5:0] RC_P1 = 6'd5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INC  = 3'd1,
    ST_SEL  = 3'd2,
    ST_CAP  = 3'd3,
    ST_HOLD = 3'd4,
    ST_DONE = 3'd5,
    ST_PARK = 3'd6
  } state_e;

  // Register-to-bus output enables, one per architectural register.
  typedef struct packed {
    logic g0;
    logic p0;
    logic g1;
    logic g2;
    logic g3;
    logic p1;
  } reg_en_t;

endpackage

// File: rtl/reg_sel_decode.sv
// Source-code decoder: 6-bit register code to one-hot bus enables.
// Shared by the MOVI and OUT sequences.
module reg_sel_decode
  import uc_pkg::*;
(
  input  logic [5:0] code,
  input  logic       en,
  output reg_en_t    sel,
  output logic       legal
);

  always_comb begin
    sel   = '0;
    legal = 1'b1;
    case (code)
      RC_G0:   sel.g0 = en;
      RC_P0:   sel.p0 = en;
      RC_G1:   sel.g1 = en;
      RC_G2:   sel.g2 = en;
      RC_G3:   sel.g3 = en;
      RC_P1:   sel.p1 = en;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/out_fsm.sv
// OUT instruction FSM: drives one register onto the shared bus, captures it
// and offers it to an external port over a valid/ready handshake.
module out_fsm
  import uc_pkg::*;
#(
  parameter logic [3:0] OPCODE  = OP_OUT,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_active,
  input  logic [15:0] fullBitNum,
  input  logic [15:0] bus_in,
  input  logic        port_ready,
  output logic        G0_out,
  output logic        G1_out,
  output logic        G2_out,
  output logic        G3_out,
  output logic        P0_out,
  output logic        P1_out,
  output logic        PC_inc,
  output logic [15:0] port_data,
  output logic        port_valid,
  output logic        err,
  output logic        done
);

  localparam logic [7:0] TMO_LAST = TIMEOUT - 8'd1;

  state_e     state, nxt;
  logic [7:0] wait_cnt;
  logic       op_hit;
  logic       legal;
  logic       tmo;
  reg_en_t    sel;
  logic       unused_low;

  assign unused_low = ^fullBitNum[5:0];
  assign op_hit     = (fullBitNum[15:12] == OPCODE) && !IF_active;
  // The wait counter reaches TIMEOUT on the edge leaving the last HOLD cycle.
  assign tmo        = (TIMEOUT != 8'd0) && (wait_cnt == TMO_LAST);

  reg_sel_decode u_dec (
    .code  (fullBitNum[11:6]),
    .en    ((state == ST_SEL) || (state == ST_CAP)),
    .sel   (sel),
    .legal (legal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (!op_hit) nxt = ST_IDLE;
    else begin
      case (state)
        ST_IDLE: nxt = ST_INC;
        ST_INC:  nxt = ST_SEL;
        ST_SEL:  nxt = legal ? ST_CAP : ST_DONE;
        ST_CAP:  nxt = ST_HOLD;
        ST_HOLD: if (port_ready || tmo) nxt = ST_DONE;
        ST_DONE: nxt = ST_PARK;
        ST_PARK: nxt = ST_PARK;
        default: nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    PC_inc     = 1'b0;
    port_valid = 1'b0;
    done       = 1'b0;
    case (state)
      ST_INC:  PC_inc     = 1'b1;
      ST_HOLD: port_valid = 1'b1;
      ST_DONE: done       = 1'b1;
      default: ;
    endcase
  end

  assign G0_out = sel.g0;
  assign G1_out = sel.g1;
  assign G2_out = sel.g2;
  assign G3_out = sel.g3;
  assign P0_out = sel.p0;
  assign P1_out = sel.p1;

  // A transfer on the timeout edge wins, so err only flags a HOLD exit without ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port_data <= 16'h0000;
      err       <= 1'b0;
      wait_cnt  <= 8'd0;
    end else begin
      if (state == ST_IDLE && nxt == ST_INC)                  err <= 1'b0;
      if (state == ST_SEL  && nxt == ST_DONE)                 err <= 1'b1;
      if (state == ST_HOLD && nxt == ST_DONE && !port_ready) err <= 1'b1;
      if (state == ST_CAP  && nxt == ST_HOLD)                 port_data <= bus_in;
      if (state != ST_HOLD)          wait_cnt <= 8'd0;
      else if (wait_cnt != TIMEOUT)  wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_out_fsm.sv
// Bench for out_fsm: two instances (default and short timeout) on shared
// stimulus, compared per cycle against a timeline model of the OUT sequence.
module tb_out_fsm;
  import uc_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, IF_active = 1'b0, port_ready = 1'b0;
  logic [15:0] fullBitNum = 16'h0000, bus_in;
  logic [5:0]  en_a, en_b;
  logic        pc_a, pv_a, dn_a, er_a, pc_b, pv_b, dn_b, er_b;
  logic [15:0] pd_a, pd_b;
  logic [25:0] cur_a, cur_b;
  logic [25:0] obs_a [64];
  logic [25:0] obs_b [64];
  logic [15:0] regs [6];
  logic [15:0] prev = 16'h0000;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  out_fsm dut (
    .clk(clk), .rst(rst), .IF_active(IF_active), .fullBitNum(fullBitNum),
    .bus_in(bus_in), .port_ready(port_ready),
    .G0_out(en_a[0]), .P0_out(en_a[1]), .G1_out(en_a[2]), .G2_out(en_a[3]),
    .G3_out(en_a[4]), .P1_out(en_a[5]), .PC_inc(pc_a), .port_data(pd_a),
    .port_valid(pv_a), .err(er_a), .done(dn_a)
  );

  out_fsm #(.TIMEOUT(8'd4)) dut_t (
    .clk(clk), .rst(rst), .IF_active(IF_active), .fullBitNum(fullBitNum),
    .bus_in(bus_in), .port_ready(port_ready),
    .G0_out(en_b[0]), .P0_out(en_b[1]), .G1_out(en_b[2]), .G2_out(en_b[3]),
    .G3_out(en_b[4]), .P1_out(en_b[5]), .PC_inc(pc_b), .port_data(pd_b),
    .port_valid(pv_b), .err(er_b), .done(dn_b)
  );

  assign cur_a = {en_a, pc_a, pv_a, dn_a, er_a, pd_a};
  assign cur_b = {en_b, pc_b, pv_b, dn_b, er_b, pd_b};

  // Register file model: whichever enable is up drives the bus.
  always_comb begin
    bus_in = 16'h5A5A;
    for (int i = 0; i < 6; i++) if (en_a[i]) bus_in = regs[i];
  end

  // Expected {en[5:0], PC_inc, port_valid, done, err} in cycle c after the
  // opcode is seen at edge 0; rdly = ready-low HOLD cycles, ab = abort cycle.
  function automatic logic [9:0] exp_ctl(input int c, code, rdly, ab, tmo);
    logic [5:0] en;
    logic pc, v, d, e, to;
    int last;
    en = '0; pc = 0; v = 0; d = 0; e = 0; to = 0;
    last = 4 + rdly;
    if (code < 6 && tmo != 0 && 3 + tmo < last) begin last = 3 + tmo; to = 1; end
    if (ab > 0 && c > ab) return {9'b0, to && ab > last};
    pc = (c == 1);
    if (code >= 6) begin d = (c == 3); e = (c >= 3); end
    else begin
      en[code] = (c == 2 || c == 3);
      v = (c >= 4 && c <= last);
      d = (c == last + 1);
      e = to && c > last;
    end
    return {en, pc, v, d, e};
  endfunction

  function automatic logic [15:0] exp_data(input int c, code, input logic [15:0] v);
    return (code < 6 && c >= 4) ? v : prev;
  endfunction

  task automatic run_op(input logic [5:0] code, input int rdly, ab, nc);
    fullBitNum = {OP_OUT, code, 6'($urandom)};
    IF_active = 0; port_ready = 0;
    for (int c = 1; c <= nc; c++) begin
      @(posedge clk); #1;
      obs_a[c] = cur_a; obs_b[c] = cur_b;
      port_ready = (c >= 4 + rdly);
      if (c == ab) begin IF_active = 1; fullBitNum[15:12] = 4'h0; end
      else IF_active = 0;
    end
    fullBitNum[15:12] = 4'h0; IF_active = 0; port_ready = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #1 rst = 0;
    #10;
    n_chk++; if (cur_a !== 26'b0) begin n_fail++; $display("FAIL reset dut got %h want 0", cur_a); end
    n_chk++; if (cur_b !== 26'b0) begin n_fail++; $display("FAIL reset dut_t got %h want 0", cur_b); end
    @(negedge clk); rst = 1;
  endtask

  task automatic test_g2_ready;
    logic [25:0] e;
    regs[3] = 16'hBEEF;
    run_op(6'd3, 0, 0, 7);
    for (int c = 1; c <= 7; c++) begin
      e = {exp_ctl(c, 3, 0, 0, 255), exp_data(c, 3, 16'hBEEF)};
      n_chk++; if (obs_a[c] !== e) begin n_fail++; $display("FAIL g2_ready cyc %0d got %h want %h", c, obs_a[c], e); end
      e = {exp_ctl(c, 3, 0, 0, 4), exp_data(c, 3, 16'hBEEF)};
      n_chk++; if (obs_b[c] !== e) begin n_fail++; $display("FAIL g2_ready_t cyc %0d got %h want %h", c, obs_b[c], e); end
    end
    prev = 16'hBEEF;
  endtask

  task automatic test_p1_wait;
    logic [25:0] e;
    logic [15:0] v = 16'($urandom);
    regs[5] = v;
    run_op(6'd5, 10, 0, 17);
    for (int c = 1; c <= 17; c++) begin
      e = {exp_ctl(c, 5, 10, 0, 255), exp_data(c, 5, v)};
      n_chk++; if (obs_a[c] !== e) begin n_fail++; $display("FAIL p1_wait cyc %0d got %h want %h", c, obs_a[c], e); end
      e = {exp_ctl(c, 5, 10, 0, 4), exp_data(c, 5, v)};
      n_chk++; if (obs_b[c] !== e) begin n_fail++; $display("FAIL p1_wait_t cyc %0d got %h want %h", c, obs_b[c], e); end
    end
    prev = v;
  endtask

  task automatic test_timeout;
    logic [25:0] e;
    logic [15:0] v = 16'($urandom);
    regs[2] = v;
    run_op(6'd2, 12, 0, 19);
    for (int c = 1; c <= 19; c++) begin
      e = {exp_ctl(c, 2, 12, 0, 4), exp_data(c, 2, v)};
      n_chk++; if (obs_b[c] !== e) begin n_fail++; $display("FAIL timeout_t cyc %0d got %h want %h", c, obs_b[c], e); end
      e = {exp_ctl(c, 2, 12, 0, 255), exp_data(c, 2, v)};
      n_chk++; if (obs_a[c] !== e) begin n_fail++; $display("FAIL timeout cyc %0d got %h want %h", c, obs_a[c], e); end
    end
    prev = v;
    n_chk++; if (er_b !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky got %b want 1", er_b); end
    v = 16'($urandom); regs[4] = v;
    run_op(6'd4, 0, 0, 7);
    for (int c = 1; c <= 7; c++) begin
      e = {exp_ctl(c, 4, 0, 0, 4), exp_data(c, 4, v)};
      n_chk++; if (obs_b[c] !== e) begin n_fail++; $display("FAIL err_clear_t cyc %0d got %h want %h", c, obs_b[c], e); end
    end
    prev = v;
  endtask

  task automatic test_illegal;
    logic [25:0] e;
    run_op(6'd9, 0, 0, 6);
    for (int c = 1; c <= 6; c++) begin
      e = {exp_ctl(c, 9, 0, 0, 255), prev};
      n_chk++; if (obs_a[c] !== e) begin n_fail++; $display("FAIL illegal cyc %0d got %h want %h", c, obs_a[c], e); end
      n_chk++; if (obs_b[c] !== e) begin n_fail++; $display("FAIL illegal_t cyc %0d got %h want %h", c, obs_b[c], e); end
    end
  endtask

  task automatic test_abort;
    logic [25:0] e;
    logic [15:0] v = 16'($urandom);
    regs[0] = v;
    run_op(6'd0, 6, 6, 9);
    for (int c = 1; c <= 9; c++) begin
      e = {exp_ctl(c, 0, 6, 6, 255), exp_data(c, 0, v)};
      n_chk++; if (obs_a[c] !== e) begin n_fail++; $display("FAIL abort cyc %0d got %h want %h", c, obs_a[c], e); end
      e = {exp_ctl(c, 0, 6, 6, 4), exp_data(c, 0, v)};
      n_chk++; if (obs_b[c] !== e) begin n_fail++; $display("FAIL abort_t cyc %0d got %h want %h", c, obs_b[c], e); end
    end
    prev = v;
  endtask

  task automatic test_if_priority;
    logic [25:0] e;
    fullBitNum = {OP_OUT, 6'd1, 6'd0}; IF_active = 1;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1;
      n_chk++; if (cur_a !== {10'b0, prev}) begin n_fail++; $display("FAIL if_wins cyc %0d got %h want %h", c, cur_a, {10'b0, prev}); end
    end
    IF_active = 0;
    @(posedge clk); #1;
    e = {exp_ctl(1, 1, 0, 0, 4), prev};
    n_chk++; if (cur_b !== e) begin n_fail++; $display("FAIL if_release got %h want %h", cur_b, e); end
    fullBitNum = 16'h0000;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_cap;
    logic [25:0] e;
    logic [15:0] v = 16'($urandom);
    regs[1] = v;
    fullBitNum = {OP_OUT, 6'd1, 6'd0};
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      e = {exp_ctl(c, 1, 0, 0, 255), prev};
      n_chk++; if (cur_a !== e) begin n_fail++; $display("FAIL rst_cap_pre cyc %0d got %h want %h", c, cur_a, e); end
    end
    rst = 0; #1;
    n_chk++; if (cur_a !== 26'b0) begin n_fail++; $display("FAIL rst_cap_async got %h want 0", cur_a); end
    n_chk++; if (cur_b !== 26'b0) begin n_fail++; $display("FAIL rst_cap_async_t got %h want 0", cur_b); end
    prev = 16'h0000;
    @(negedge clk); rst = 1;
    run_op(6'd1, 0, 0, 7);
    for (int c = 1; c <= 7; c++) begin
      e = {exp_ctl(c, 1, 0, 0, 255), exp_data(c, 1, v)};
      n_chk++; if (obs_a[c] !== e) begin n_fail++; $display("FAIL rst_cap_restart cyc %0d got %h want %h", c, obs_a[c], e); end
    end
    prev = v;
  endtask

  task automatic test_random;
    logic [25:0] e;
    int code, rdly, ab, nc;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 6; i++) regs[i] = 16'($urandom);
      code = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 63) : $urandom_range(0, 5);
      rdly = $urandom_range(0, 8);
      ab   = (code < 6 && $urandom_range(0, 3) == 0) ? $urandom_range(4, 4 + rdly) : 0;
      nc   = (ab > 0) ? ab + 3 : ((code < 6) ? rdly + 7 : 6);
      run_op(6'(code), rdly, ab, nc);
      for (int c = 1; c <= nc; c++) begin
        e = {exp_ctl(c, code, rdly, ab, 255), exp_data(c, code, (code < 6) ? regs[code] : prev)};
        n_chk++; if (obs_a[c] !== e) begin n_fail++; $display("FAIL random op %0d cyc %0d got %h want %h", n, c, obs_a[c], e); end
        e = {exp_ctl(c, code, rdly, ab, 4), exp_data(c, code, (code < 6) ? regs[code] : prev)};
        n_chk++; if (obs_b[c] !== e) begin n_fail++; $display("FAIL random_t op %0d cyc %0d got %h want %h", n, c, obs_b[c], e); end
      end
      if (code < 6) prev = regs[code];
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) regs[i] = 16'h0000;
    test_reset();
    test_g2_ready();
    test_p1_wait();
    test_timeout();
    test_illegal();
    test_abort();
    test_if_priority();
    test_reset_mid_cap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
